// File: rtl/pkg_ram.sv
// RAM interface encodings shared by the RAM, its masters and the arbiter.
// Provides the operation and access-size types plus the address width.
package pkg_ram;

    localparam int RAM_ADDRW = 16;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_FETCH = 2'd1,
        RAM_STORE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_QUAD = 2'd3
    } size_t;

endpackage

// File: rtl/ram_arbiter_pkg.sv
// Types for the two-master RAM arbiter: FSM states, master ids,
// the latency-counter width and a helper returning the other master.
package pkg_arb;

    localparam int LAT_CNTW = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    function automatic master_t other_master(master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
// Ports: req0/req1 requests, last_served -> valid (any request), sel (winner).
module rr_pick2
    import pkg_arb::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_t last_served,
    output logic    valid,
    output master_t sel
);

    always_comb begin
        valid = req0 | req1;
        sel   = M0;
        unique case ({req0, req1})
            2'b11:   sel = other_master(last_served);
            2'b01:   sel = M1;
            default: sel = M0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between two masters with round-robin priority.
// Ports: clk/rst; per master req/op/size/addr/data_in in, gnt/done/data_out out;
// ram_op/size/addr/data_in to the RAM, ram_data_out from it; busy when not idle.
module ram_arbiter
    import pkg_ram::*;
    import pkg_arb::*;
#(
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int RAM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  op_t              m0_op,
    input  size_t            m0_size,
    input  logic [ADDRW-1:0] m0_addr,
    input  logic [DATAW-1:0] m0_data_in,
    output logic             m0_gnt,
    output logic             m0_done,
    output logic [DATAW-1:0] m0_data_out,
    input  logic             m1_req,
    input  op_t              m1_op,
    input  size_t            m1_size,
    input  logic [ADDRW-1:0] m1_addr,
    input  logic [DATAW-1:0] m1_data_in,
    output logic             m1_gnt,
    output logic             m1_done,
    output logic [DATAW-1:0] m1_data_out,
    output op_t              ram_op,
    output size_t            ram_size,
    output logic [ADDRW-1:0] ram_addr,
    output logic [DATAW-1:0] ram_data_in,
    input  logic [DATAW-1:0] ram_data_out,
    output logic             busy
);

    state_t              state_q, state_d;
    master_t             last_q, last_d;
    master_t             owner_q;
    master_t             pick_sel;
    logic                pick_valid;
    op_t                 iss_op_q;
    size_t               iss_size_q;
    logic [ADDRW-1:0]    iss_addr_q;
    logic [DATAW-1:0]    iss_data_q;
    logic [LAT_CNTW-1:0] lat_q, lat_d;
    logic [DATAW-1:0]    dout0_q, dout1_q;
    op_t                 sel_op;
    logic                latch;
    logic                gnt0, gnt1, done0, done1;
    logic                fin, fetch_fin;

    rr_pick2 u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_served (last_q),
        .valid       (pick_valid),
        .sel         (pick_sel)
    );

    assign sel_op    = (pick_sel == M1) ? m1_op : m0_op;
    assign fin       = (state_q == ARB_WAIT) && (lat_q == '0);
    assign fetch_fin = fin && (iss_op_q == RAM_FETCH);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lat_d   = lat_q;
        latch   = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt0 = (pick_sel == M0);
                    gnt1 = (pick_sel == M1);
                    // A NOP completes in place without touching the RAM.
                    if (sel_op == RAM_NOP) begin
                        done0  = gnt0;
                        done1  = gnt1;
                        last_d = pick_sel;
                    end else begin
                        latch   = 1'b1;
                        state_d = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                lat_d   = LAT_CNTW'(RAM_LAT - 1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LAT_CNTW'(1);
                end else begin
                    done0   = (owner_q == M0);
                    done1   = (owner_q == M1);
                    last_d  = owner_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_q     <= M1;
            owner_q    <= M0;
            lat_q      <= '0;
            iss_op_q   <= RAM_NOP;
            iss_size_q <= SZ_BYTE;
            iss_addr_q <= '0;
            iss_data_q <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lat_q   <= lat_d;
            if (latch) begin
                owner_q    <= pick_sel;
                iss_op_q   <= sel_op;
                iss_size_q <= (pick_sel == M1) ? m1_size : m0_size;
                iss_addr_q <= (pick_sel == M1) ? m1_addr : m0_addr;
                iss_data_q <= (pick_sel == M1) ? m1_data_in : m0_data_in;
            end
            if (fetch_fin && owner_q == M0) dout0_q <= ram_data_out;
            if (fetch_fin && owner_q == M1) dout1_q <= ram_data_out;
        end
    end

    // RAM sees an operation only in ISSUE; everything else comes from registers.
    assign ram_op      = (state_q == ARB_ISSUE) ? iss_op_q : RAM_NOP;
    assign ram_size    = iss_size_q;
    assign ram_addr    = iss_addr_q;
    assign ram_data_in = iss_data_q;
    assign busy        = (state_q != ARB_IDLE);

    // Gated so a request held during reset never shows a pulse.
    assign m0_gnt  = gnt0 & ~rst;
    assign m1_gnt  = gnt1 & ~rst;
    assign m0_done = done0 & ~rst;
    assign m1_done = done1 & ~rst;

    // Fetch data is forwarded in the done cycle, then held in the register.
    assign m0_data_out = (fetch_fin && owner_q == M0) ? ram_data_out : dout0_q;
    assign m1_data_out = (fetch_fin && owner_q == M1) ? ram_data_out : dout1_q;

endmodule
